obstacle_spawn_ctrl: RTL and testbench

Lifecycle controller for one falling obstacle in the Space Adventure playfield. Runs a frame-based cooldown, then requests a fresh random X by pulsing the rise input of the obstacle's random-X generator. It latches the generator's output as the spawn column and moves the obstacle down one step per frame. The obstacle retires on reaching the screen bottom or on collision. Outputs feed the obstacle's square/bitmap drawer and the collision logic.

---
 rtl/obstacle_pkg.sv | 16 +
 rtl/obstacle_cooldown_timer.sv | 36 +++
 rtl/obstacle_spawn_ctrl.sv | 101 ++++++++++
 tb/tb_obstacle_spawn_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared types and constants for the obstacle lanes
package obstacle_pkg;

   localparam int COORD_W       = 11;
   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;

   typedef enum logic [2:0] {
      S_COOL,
      S_REQ,
      S_WAIT,
      S_LATCH,
      S_FALL
   } obst_state_e;

endpackage

// File: rtl/obstacle_cooldown_timer.sv
// rtl/obstacle_cooldown_timer.sv - frame-pulse counter with clear and terminal-count pulse
module obstacle_cooldown_timer #(
   parameter int FRAMES = 60
) (
   input  logic clk,
   input  logic resetN,
   input  logic tick_i,
   input  logic clear_i,
   output logic tc_o
);

   localparam int CNT_W = (FRAMES < 2) ? 1 : $clog2(FRAMES);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // tc_o fires on the tick that completes the count, so the counter never holds FRAMES
   always_comb begin
      tc_o    = tick_i && (count_q == CNT_W'(FRAMES - 1));
      count_d = count_q;
      if (clear_i || tc_o) begin
         count_d = '0;
      end else if (tick_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/obstacle_spawn_ctrl.sv
// rtl/obstacle_spawn_ctrl.sv - cooldown, random-X spawn request and per-frame fall of one obstacle
module obstacle_spawn_ctrl
   import obstacle_pkg::*;
#(
   parameter int X_MIN           = 32,
   parameter int X_SHIFT         = 1,
   parameter int START_Y         = -32,
   parameter int SCREEN_H        = SCREEN_HEIGHT,
   parameter int SPEED           = 2,
   parameter int COOLDOWN_FRAMES = 60
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      startOfFrame,
   input  logic                      enable,
   input  logic                      collision,
   input  logic [7:0]                random_x,
   output logic                      spawn_rise,
   output logic signed [COORD_W-1:0] topLeftX,
   output logic signed [COORD_W-1:0] topLeftY,
   output logic                      active
);

   localparam logic signed [COORD_W-1:0] X_RESET = COORD_W'(X_MIN);
   localparam logic signed [COORD_W-1:0] Y_START = COORD_W'(START_Y);
   localparam logic signed [COORD_W-1:0] Y_STEP  = COORD_W'(SPEED);
   localparam logic signed [COORD_W-1:0] Y_LIMIT = COORD_W'(SCREEN_H);

   obst_state_e               state_q;
   logic                      spawn_rise_q;
   logic                      active_q;
   logic signed [COORD_W-1:0] x_q;
   logic signed [COORD_W-1:0] y_q;
   logic signed [COORD_W-1:0] x_spawn_d;
   logic signed [COORD_W-1:0] y_next_d;
   logic                      frame_tick;
   logic                      cool_done;

   assign frame_tick = startOfFrame && enable;
   assign x_spawn_d  = X_RESET + (COORD_W'(random_x) << X_SHIFT);
   assign y_next_d   = y_q + Y_STEP;

   obstacle_cooldown_timer #(
      .FRAMES (COOLDOWN_FRAMES)
   ) u_cooldown (
      .clk     (clk),
      .resetN  (resetN),
      .tick_i  (frame_tick && (state_q == S_COOL)),
      .clear_i (state_q != S_COOL),
      .tc_o    (cool_done)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= S_COOL;
         spawn_rise_q <= 1'b0;
         active_q     <= 1'b0;
         x_q          <= X_RESET;
         y_q          <= Y_START;
      end else begin
         spawn_rise_q <= 1'b0;
         unique case (state_q)
            S_COOL: begin
               if (cool_done) begin
                  state_q      <= S_REQ;
                  spawn_rise_q <= 1'b1;
               end
            end
            // WAIT gives the generator a settled latch and a low phase before the next request
            S_REQ:   state_q <= S_WAIT;
            S_WAIT:  state_q <= S_LATCH;
            S_LATCH: begin
               x_q      <= x_spawn_d;
               y_q      <= Y_START;
               active_q <= 1'b1;
               state_q  <= S_FALL;
            end
            S_FALL: begin
               if (enable && collision) begin
                  active_q <= 1'b0;
                  state_q  <= S_COOL;
               end else if (frame_tick) begin
                  if (y_next_d >= Y_LIMIT) begin
                     active_q <= 1'b0;
                     state_q  <= S_COOL;
                  end else begin
                     y_q <= y_next_d;
                  end
               end
            end
            default: state_q <= S_COOL;
         endcase
      end
   end

   assign spawn_rise = spawn_rise_q;
   assign active     = active_q;
   assign topLeftX   = x_q;
   assign topLeftY   = y_q;

endmodule

// File: tb/tb_obstacle_spawn_ctrl.sv
// tb/tb_obstacle_spawn_ctrl.sv - randomized and directed checks of obstacle_spawn_ctrl against a behavioural model
module tb_obstacle_spawn_ctrl;

   logic               clk = 1'b0;
   logic               resetN = 1'b0;
   logic               startOfFrame = 1'b0;
   logic               enable = 1'b0;
   logic               collision = 1'b0;
   logic [7:0]         random_x = 8'd0;
   logic               spawn_rise;
   logic               active;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;

   int n_tests  = 0;
   int n_fail   = 0;
   int rise_cnt = 0;

   obstacle_spawn_ctrl dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .enable       (enable),
      .collision    (collision),
      .random_x     (random_x),
      .spawn_rise   (spawn_rise),
      .topLeftX     (topLeftX),
      .topLeftY     (topLeftY),
      .active       (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Behavioural model: cooldown frames seen, cycles since the request, and the obstacle itself
   int m_frames, m_since_req, m_x, m_y;
   bit m_vis, m_rise;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_frames = 0; m_since_req = 0; m_vis = 0; m_rise = 0;
         m_x = 32; m_y = -32;
      end else begin
         if (m_since_req != 0) begin
            if (m_since_req == 3) begin
               m_since_req = 0;
               m_vis = 1;
               m_x = 32 + 2 * int'(random_x);
               m_y = -32;
            end else begin
               m_since_req++;
            end
         end else if (m_vis) begin
            if (enable && collision) m_vis = 0;
            else if (enable && startOfFrame) begin
               if (m_y + 2 >= 480) m_vis = 0;
               else m_y += 2;
            end
         end else if (enable && startOfFrame) begin
            m_frames++;
            if (m_frames == 60) begin
               m_frames = 0;
               m_since_req = 1;
            end
         end
         m_rise = (m_since_req == 1);
      end
   end

   always @(posedge clk) begin
      #3;
      if (spawn_rise) rise_cnt++;
      chk("model_rise",   int'(spawn_rise), int'(m_rise));
      chk("model_active", int'(active), int'(m_vis));
      chk("model_x",      int'(topLeftX), m_x);
      chk("model_y",      int'(topLeftY), m_y);
   end

   task automatic cycle(input logic sof, input logic col);
      @(negedge clk);
      startOfFrame = sof;
      collision    = col;
   endtask

   task automatic frame();
      cycle(1'b1, 1'b0);
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   // Expects the controller in a fresh cooldown with enable high
   task automatic cool_and_spawn(input int rx, input int exp_x);
      int r0;
      enable   = 1'b1;
      random_x = rx[7:0];
      r0 = rise_cnt;
      frames(59);
      chk("no_early_rise", rise_cnt, r0);
      chk("inactive_in_cool", int'(active), 0);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      chk("rise_after_60th", int'(spawn_rise), 1);
      cycle(1'b0, 1'b0);
      chk("rise_one_cycle", int'(spawn_rise), 0);
      chk("inactive_wait", int'(active), 0);
      cycle(1'b0, 1'b0);
      chk("inactive_latch", int'(active), 0);
      cycle(1'b0, 1'b0);
      chk("spawn_active", int'(active), 1);
      chk("spawn_x", int'(topLeftX), exp_x);
      chk("spawn_y", int'(topLeftY), -32);
   endtask

   initial begin
      int r;
      repeat (3) @(negedge clk);
      chk("reset_rise",   int'(spawn_rise), 0);
      chk("reset_active", int'(active), 0);
      chk("reset_x",      int'(topLeftX), 32);
      chk("reset_y",      int'(topLeftY), -32);
      resetN = 1'b1;

      cool_and_spawn(100, 232);
      frames(255);
      chk("y_before_bottom", int'(topLeftY), 478);
      chk("active_before_bottom", int'(active), 1);
      frame();
      chk("retire_active", int'(active), 0);
      chk("retire_y", int'(topLeftY), 478);

      cool_and_spawn(0, 32);
      frames(41);
      chk("y_at_50", int'(topLeftY), 50);
      enable = 1'b0;
      frames(10);
      chk("frozen_y", int'(topLeftY), 50);
      enable = 1'b1;
      frame();
      chk("resumed_y", int'(topLeftY), 52);
      frames(24);
      chk("y_at_100", int'(topLeftY), 100);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b0);
      chk("collision_active", int'(active), 0);
      chk("collision_y", int'(topLeftY), 100);

      cool_and_spawn(255, 542);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         enable       = ($urandom_range(0, 9) != 0);
         startOfFrame = ($urandom_range(0, 3) == 0);
         collision    = ($urandom_range(0, 19) == 0);
         random_x     = 8'($urandom);
      end

      @(negedge clk);
      enable = 1'b1; startOfFrame = 1'b0; collision = 1'b0;
      resetN = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      frames(59);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      chk("pre_reset_rise", int'(spawn_rise), 1);
      @(posedge clk);
      #2 resetN = 1'b0;
      #1;
      chk("async_rise",   int'(spawn_rise), 0);
      chk("async_active", int'(active), 0);
      chk("async_x",      int'(topLeftX), 32);
      chk("async_y",      int'(topLeftY), -32);
      @(negedge clk);
      resetN = 1'b1;
      r = $urandom_range(0, 255);
      cool_and_spawn(r, 32 + 2 * r);
      frames(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
